swc_rr_prio_encoder: RTL and testbench
======================================

# swc_rr_prio_encoder

Registered, handshaked priority encoder for the switch core. It supports two modes: fixed lowest-index priority, and round-robin priority with a rotating pointer. It samples a request vector, selects one requester, presents the selection as both a binary index and a one-hot vector, and holds it until the consumer acknowledges. It sits between the per-port request vectors and the shared resource allocators, replacing bare combinational encoding where fairness and a registered output are needed.

## Interface
- g_num_inputs, 36, number of request lines N (2..64, need not be a power of 2)
- g_output_bits, 6, index width B; must satisfy 2^B >= N
- clk_i  in  1  system clock; all state changes on the rising edge
- rst_i  in  1  asynchronous, active-high reset
- req_i  in  N  request vector; bit i set means requester i wants service
- mode_rr_i  in  1  0 selects fixed priority (lowest index wins); 1 selects round-robin
- ack_i  in  1  consumer accepts the current grant
- valid_o  out  1  a grant is being presented
- grant_idx_o  out  B  index of the granted requester
- grant_onehot_o  out  N  one-hot form of grant_idx_o; all zero when valid_o=0

## Operation
- State machine has two states, IDLE and GRANT. Reset enters IDLE.
- **IDLE:** on a clock edge with req_i != 0, load a grant from req_i and go to GRANT. Otherwise stay in IDLE.
- **GRANT:** outputs are frozen while ack_i=0, whatever req_i and mode_rr_i do.
- **GRANT with ack_i=1 (transfer):**
  - Form the candidate vector req_i & ~grant_onehot_o, so the just-granted line is excluded for one decision.
  - If the candidate vector is non-zero, load a new grant from it and stay in GRANT.
  - Otherwise go to IDLE.
- **Fixed-priority selection:** the lowest set bit of the candidate vector.
- **Round-robin selection:**
  - Pointer P has range 0..N-1 and resets to 0.
  - Select the lowest set bit at index >= P. If there is none, select the lowest set bit overall.
  - On every transfer, P becomes granted index + 1. P wraps from N-1 to 0, not to 2^B.
- Mode is sampled at each load edge; a change during GRANT takes effect at the next load.
- grant_idx_o is zero-extended to B bits.

## Timing
- Reset values: valid_o=0, grant_idx_o=0, grant_onehot_o=0, P=0, state IDLE.
- Reset acts immediately, including mid-GRANT; a pending grant is discarded without a transfer.
- Latency: req_i valid before edge n gives valid_o=1 after edge n (1 cycle).
- Throughput: one grant per cycle when ack_i is held high and other requesters are pending. No bubble between back-to-back grants.
- A transfer happens only on an edge where valid_o=1 and ack_i=1. ack_i while valid_o=0 is ignored.
- All outputs come straight from registers; there is no combinational path from req_i or ack_i to the outputs.

## Configuration
- Macro: SWC_RR_PRIO_ENCODER_RR_EN.
- **Defined:** the round-robin pointer and masked search are compiled in, and mode_rr_i selects the mode.
- **Undefined:** pointer logic is removed, selection is always fixed priority, and mode_rr_i is accepted but ignored. Ports and timing are otherwise identical.

## Structure
- Shared package swc_rr_prio_encoder_pkg holds:
  - the state enumeration (IDLE, GRANT);
  - a width-check constant function computing the minimum B for a given N, used by a parameter assertion.
- Sub-module: the existing combinational swc_prio_encoder.
  - Two instances: one on the pointer-masked candidates, one on the unmasked candidates.
  - The wrapper picks the masked result when the masked vector is non-zero.
  - Without the macro only the unmasked instance exists.

## Test plan
N=36 and B=6 throughout.
- **Reset:** hold rst_i high with req_i all ones → valid_o=0, grant_idx_o=0, grant_onehot_o=0. Assert rst_i mid-GRANT → outputs return to zero asynchronously, before the next edge.
- **Fixed priority and exclusion:** mode_rr_i=0, req_i=0x8_0000_0010.
  - One edge later: valid_o=1, idx=4.
  - Ack with req_i unchanged → next idx=35.
  - Ack with req_i=0x10 → IDLE, valid_o=0.
- **Round-robin rotation:** mode_rr_i=1, req_i all ones, ack_i held high → idx sequence 0,1,…,35,0,1 with valid_o continuously 1.
- **Hold under backpressure:** grant idx=7, ack_i=0 for 5 cycles while req_i toggles randomly → idx=7 and onehot=0x80 stay stable. valid_o stays 1 throughout.
- **Round-robin wrap and skip:** mode_rr_i=1, P=30, req_i with bits 3 and 20 set → idx=3, then idx=20 on the next ack.
- **Macro off:** rebuild without SWC_RR_PRIO_ENCODER_RR_EN, mode_rr_i=1, req_i all ones, ack_i held high → idx alternates 0,1,0,1.

Source files
------------

// File: rtl/swc_rr_prio_encoder_pkg.sv
// Shared definitions for the registered round-robin / fixed priority encoder:
// the grant state machine encoding and the index-width helper used by the
// parameter check in the top level.
package swc_rr_prio_encoder_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Smallest index width B such that 2^B >= n.
  function automatic int min_index_bits(input int n);
    int b;
    b = 0;
    while ((64'd1 << b) < 64'(n)) begin
      b = b + 1;
    end
    return b;
  endfunction

endpackage

// File: rtl/swc_rr_prio_encoder_prio.sv
// Combinational lowest-index priority encoder (swc_prio_encoder).
// Reports whether any request is set, the index of the lowest set bit and the
// same selection as a one-hot vector. Index and one-hot are zero when idle.
module swc_prio_encoder #(
  parameter int g_num_inputs  = 36,
  parameter int g_output_bits = 6
) (
  input  logic [g_num_inputs-1:0]  req,
  output logic                     any,
  output logic [g_output_bits-1:0] idx,
  output logic [g_num_inputs-1:0]  onehot
);

  localparam int N = g_num_inputs;
  localparam int B = g_output_bits;

  // Scan upward; the first set bit seen wins and masks all higher bits.
  always_comb begin
    any    = 1'b0;
    idx    = {B{1'b0}};
    onehot = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      onehot[i] = req[i] & ~any;
      idx       = (req[i] & ~any) ? B'(i) : idx;
      any       = any | req[i];
    end
  end

endmodule

// File: rtl/swc_rr_prio_encoder.sv
// Registered, handshaked priority encoder with optional round-robin mode.
// A grant is loaded from the request vector and held until ack_i; on each
// transfer the just-granted line is excluded for one decision.
// Build option: define SWC_RR_PRIO_ENCODER_RR_EN to compile in the rotating
// pointer and masked search (mode_rr_i then selects round-robin). Without it
// selection is always lowest-index-first and mode_rr_i is ignored.
module swc_rr_prio_encoder
  import swc_rr_prio_encoder_pkg::*;
#(
  parameter int g_num_inputs  = 36,
  parameter int g_output_bits = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [g_num_inputs-1:0]  req_i,
  input  logic                     mode_rr_i,
  input  logic                     ack_i,
  output logic                     valid_o,
  output logic [g_output_bits-1:0] grant_idx_o,
  output logic [g_num_inputs-1:0]  grant_onehot_o
);

  localparam int N = g_num_inputs;
  localparam int B = g_output_bits;

  if ((g_num_inputs < 2) || (g_num_inputs > 64) ||
      (g_output_bits < min_index_bits(g_num_inputs))) begin : g_bad_params
    $error("swc_rr_prio_encoder: g_num_inputs must be 2..64 and 2^g_output_bits >= g_num_inputs");
  end

  state_e         state_r;
  state_e         state_nxt_s;
  logic           valid_r;
  logic [B-1:0]   grant_idx_r;
  logic [N-1:0]   grant_onehot_r;

  logic [N-1:0]   cand_s;
  logic           load_s;
  logic           transfer_s;
  logic [B-1:0]   sel_idx_s;
  logic [N-1:0]   sel_onehot_s;

  logic           full_any_s;
  logic [B-1:0]   full_idx_s;
  logic [N-1:0]   full_onehot_s;

  // The current grant is removed from the candidates; in IDLE the one-hot is zero.
  assign cand_s     = req_i & ~grant_onehot_r;
  assign transfer_s = valid_r & ack_i;

  swc_prio_encoder #(
    .g_num_inputs  (N),
    .g_output_bits (B)
  ) u_enc_full (
    .req    (cand_s),
    .any    (full_any_s),
    .idx    (full_idx_s),
    .onehot (full_onehot_s)
  );

`ifdef SWC_RR_PRIO_ENCODER_RR_EN
  logic [B-1:0]   ptr_r;
  logic [B-1:0]   ptr_inc_s;
  logic [B-1:0]   search_ptr_s;
  logic [N-1:0]   mask_s;
  logic           masked_any_s;
  logic [B-1:0]   masked_idx_s;
  logic [N-1:0]   masked_onehot_s;

  // Pointer value after the current grant transfers: one past it, wrapping at N.
  always_comb begin
    if (grant_idx_r == B'(N - 1)) begin
      ptr_inc_s = {B{1'b0}};
    end else begin
      ptr_inc_s = grant_idx_r + {{(B-1){1'b0}}, 1'b1};
    end
  end

  // A load on a transfer edge already searches from the updated pointer.
  always_comb begin
    if (transfer_s) begin
      search_ptr_s = ptr_inc_s;
    end else begin
      search_ptr_s = ptr_r;
    end
  end

  // Keep only candidates at or above the search pointer.
  always_comb begin
    mask_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      mask_s[i] = (B'(i) >= search_ptr_s);
    end
  end

  swc_prio_encoder #(
    .g_num_inputs  (N),
    .g_output_bits (B)
  ) u_enc_masked (
    .req    (cand_s & mask_s),
    .any    (masked_any_s),
    .idx    (masked_idx_s),
    .onehot (masked_onehot_s)
  );

  // Round-robin takes the masked winner if any, else wraps to the lowest overall.
  always_comb begin
    if (mode_rr_i && masked_any_s) begin
      sel_idx_s    = masked_idx_s;
      sel_onehot_s = masked_onehot_s;
    end else begin
      sel_idx_s    = full_idx_s;
      sel_onehot_s = full_onehot_s;
    end
  end

  // Round-robin pointer advances on every transfer, in either mode.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_r <= {B{1'b0}};
    end else if (transfer_s) begin
      ptr_r <= ptr_inc_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  logic unused_mode_s;
  assign unused_mode_s = mode_rr_i;

  // Fixed priority only: lowest candidate index wins.
  always_comb begin
    sel_idx_s    = full_idx_s;
    sel_onehot_s = full_onehot_s;
  end
`endif

  // Next-state and load decision for the IDLE/GRANT handshake.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (full_any_s) begin
          state_nxt_s = GRANT;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        if (ack_i) begin
          if (full_any_s) begin
            state_nxt_s = GRANT;
            load_s      = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = GRANT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output registers: load a new grant, clear on return to IDLE, else hold.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_r        <= 1'b0;
      grant_idx_r    <= {B{1'b0}};
      grant_onehot_r <= {N{1'b0}};
    end else if (load_s) begin
      valid_r        <= 1'b1;
      grant_idx_r    <= sel_idx_s;
      grant_onehot_r <= sel_onehot_s;
    end else if (state_nxt_s == IDLE) begin
      valid_r        <= 1'b0;
      grant_idx_r    <= {B{1'b0}};
      grant_onehot_r <= {N{1'b0}};
    end else begin
      valid_r        <= valid_r;
      grant_idx_r    <= grant_idx_r;
      grant_onehot_r <= grant_onehot_r;
    end
  end

  assign valid_o        = valid_r;
  assign grant_idx_o    = grant_idx_r;
  assign grant_onehot_o = grant_onehot_r;

endmodule

// File: tb/tb_swc_rr_prio_encoder.sv
// Self-checking bench for swc_rr_prio_encoder (N=36, B=6). A rotating-search
// reference model predicts every cycle; directed phases pin literal results.
// Works with or without SWC_RR_PRIO_ENCODER_RR_EN defined.
module tb_swc_rr_prio_encoder;

  localparam int N = 36;
  localparam int B = 6;

`ifdef SWC_RR_PRIO_ENCODER_RR_EN
  localparam bit RR_BUILT = 1'b1;
`else
  localparam bit RR_BUILT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         mode_rr;
  logic         ack;
  logic         valid;
  logic [B-1:0] idx;
  logic [N-1:0] onehot;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_valid;
  int m_idx;
  int m_ptr;

  always #5 clk = ~clk;

  swc_rr_prio_encoder #(
    .g_num_inputs  (N),
    .g_output_bits (B)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req),
    .mode_rr_i      (mode_rr),
    .ack_i          (ack),
    .valid_o        (valid),
    .grant_idx_o    (idx),
    .grant_onehot_o (onehot)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Selection rule: fixed = lowest set bit; rr = first set bit walking up from p, wrapping.
  function automatic int pick(input logic [N-1:0] v, input bit rr, input int p);
    int j;
    for (int k = 0; k < N; k++) begin
      j = rr ? ((p + k) % N) : k;
      if (v[j]) return j;
    end
    return 0;
  endfunction

  function automatic logic [N-1:0] excl(input logic [N-1:0] v, input int i);
    logic [N-1:0] r;
    r    = v;
    r[i] = 1'b0;
    return r;
  endfunction

  function automatic int nxt_ptr(input int i);
    return RR_BUILT ? ((i + 1) % N) : 0;
  endfunction

  // Reference model, advanced on each active edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_idx   <= 0;
      m_ptr   <= 0;
    end else if (!m_valid) begin
      if (req != '0) begin
        m_idx   <= pick(req, mode_rr && RR_BUILT, m_ptr);
        m_valid <= 1'b1;
      end
    end else if (ack) begin
      m_ptr <= nxt_ptr(m_idx);
      if (excl(req, m_idx) != '0) begin
        m_idx <= pick(excl(req, m_idx), mode_rr && RR_BUILT, nxt_ptr(m_idx));
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  // Compare DUT against the model on every falling edge out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("model_valid", 64'(valid), 64'(m_valid));
      check("model_onehot", 64'(onehot), m_valid ? (64'd1 << m_idx) : 64'd0);
      if (m_valid) check("model_idx", 64'(idx), 64'(m_idx));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '1; mode_rr = 1'b0; ack = 1'b0;

    // reset with all requests high
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_idx", 64'(idx), 64'd0);
    check("rst_onehot", 64'(onehot), 64'd0);

    // fixed priority and exclusion
    @(negedge clk);
    rst = 1'b0; mode_rr = 1'b0; req = 36'h8_0000_0010; ack = 1'b0;
    @(posedge clk); #1;
    check("fix_valid", 64'(valid), 64'd1);
    check("fix_idx4", 64'(idx), 64'd4);
    @(negedge clk); ack = 1'b1;
    @(posedge clk); #1;
    check("fix_idx35", 64'(idx), 64'd35);
    @(posedge clk); #1;
    check("fix_idx4_again", 64'(idx), 64'd4);
    @(negedge clk); req = 36'h10;
    @(posedge clk); #1;
    check("fix_idle_valid", 64'(valid), 64'd0);
    check("fix_idle_onehot", 64'(onehot), 64'd0);
    @(negedge clk); req = '0; ack = 1'b0;

    // asynchronous reset mid-grant
    @(negedge clk); req = 36'h100;
    @(posedge clk); #1;
    check("arst_pre_idx", 64'(idx), 64'd8);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(valid), 64'd0);
    check("arst_idx", 64'(idx), 64'd0);
    check("arst_onehot", 64'(onehot), 64'd0);

    // hold under backpressure
    @(negedge clk);
    rst = 1'b0; req = 36'h80; mode_rr = 1'b0; ack = 1'b0;
    @(posedge clk); #1;
    check("hold_idx", 64'(idx), 64'd7);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req = N'({$urandom(), $urandom()});
      mode_rr = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("hold_idx", 64'(idx), 64'd7);
      check("hold_onehot", 64'(onehot), 64'h80);
      check("hold_valid", 64'(valid), 64'd1);
    end

    // round-robin rotation with all requesters pending
    do_reset();
    mode_rr = 1'b1; req = '1; ack = 1'b1;
    for (int k = 0; k < N + 2; k++) begin
      @(posedge clk); #1;
      check("rr_seq_valid", 64'(valid), 64'd1);
      check("rr_seq_idx", 64'(idx), RR_BUILT ? 64'(k % N) : 64'(k % 2));
    end

    // round-robin wrap and skip from pointer 30
    do_reset();
    mode_rr = 1'b1; req = 36'd1 << 29; ack = 1'b0;
    @(posedge clk); #1;
    check("wrap_idx29", 64'(idx), 64'd29);
    @(negedge clk); req = (36'd1 << 3) | (36'd1 << 20); ack = 1'b1;
    @(posedge clk); #1;
    check("wrap_idx3", 64'(idx), 64'd3);
    @(posedge clk); #1;
    check("wrap_idx20", 64'(idx), 64'd20);
    @(negedge clk); ack = 1'b0; req = '0;

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      rst     = ($urandom_range(0, 149) == 0);
      mode_rr = 1'($urandom_range(0, 1));
      ack     = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: req = N'({$urandom(), $urandom()}) & N'({$urandom(), $urandom()}) & N'({$urandom(), $urandom()});
        1: req = N'({$urandom(), $urandom()});
        2: req = N'(36'd1 << $urandom_range(0, N - 1));
        default: req = '0;
      endcase
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
